// File: rtl/fft64_corner_turn_if.sv
`default_nettype none
// ============================================================================
// Module   : fft64_corner_turn_if
// Purpose  : Row-in / column-out stream bundle for the FFT64 corner-turn buffer.
// Revision : 1.0
// ============================================================================
interface fft64_corner_turn_if #(
    parameter int LANES = 8,
    parameter int DW    = 10,
    parameter int CW    = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] dinre;
    logic [LANES*DW-1:0] dinim;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*DW-1:0] doutre;
    logic [LANES*DW-1:0] doutim;
    logic [CW-1:0]       counter;
    logic                out_last;

    // Environment side: produces rows and consumes columns.
    modport master (
        output in_valid, dinre, dinim, out_ready,
        input  in_ready, out_valid, doutre, doutim, counter, out_last
    );

    // Buffer side.
    modport slave (
        input  in_valid, dinre, dinim, out_ready,
        output in_ready, out_valid, doutre, doutim, counter, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft64_corner_turn.sv
`default_nettype none
// ============================================================================
// Module   : fft64_corner_turn
// Purpose  : Ping-pong 8x8 complex transpose buffer; rows in, columns out with
//            the column index used as the twiddle-row selector.
// Revision : 1.0
// ============================================================================
module fft64_corner_turn #(
    parameter int LANES = 8,
    parameter int DW    = 10,
    parameter int CW    = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fft64_corner_turn_if.slave bus
);
    localparam int              PW       = $clog2(LANES);
    localparam int              BW       = LANES * DW;
    localparam logic [PW-1:0]   ROW_LAST = PW'(LANES - 1);

    logic [BW-1:0] mem_re_q [2][LANES];
    logic [BW-1:0] mem_im_q [2][LANES];

    logic [1:0]    full_q,      full_d;
    logic          wbank_q,     wbank_d;
    logic          rbank_q,     rbank_d;
    logic [PW-1:0] wrow_q,      wrow_d;
    logic [PW-1:0] rcol_q,      rcol_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] doutre_q,    doutre_d;
    logic [BW-1:0] doutim_q,    doutim_d;
    logic [PW-1:0] counter_q,   counter_d;
    logic          out_last_q,  out_last_d;

    logic          w_in_ready;
    logic          w_wr;
    logic          w_load;
    logic [BW-1:0] w_col_re;
    logic [BW-1:0] w_col_im;

    assign w_in_ready = !full_q[wbank_q];
    assign w_wr       = bus.in_valid && w_in_ready;
    assign w_load     = full_q[rbank_q] && (!out_valid_q || bus.out_ready);

    // Column rcol of the read bank: lane r comes from row r, lane rcol.
    for (genvar r = 0; r < LANES; r++) begin : g_lane
        assign w_col_re[DW*r +: DW] = mem_re_q[rbank_q][r][DW*rcol_q +: DW];
        assign w_col_im[DW*r +: DW] = mem_im_q[rbank_q][r][DW*rcol_q +: DW];
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_re_q[wbank_q][wrow_q] <= bus.dinre;
            mem_im_q[wbank_q][wrow_q] <= bus.dinim;
        end
    end

    always_comb begin
        full_d      = full_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wrow_d      = wrow_q;
        rcol_d      = rcol_q;
        out_valid_d = out_valid_q;
        doutre_d    = doutre_q;
        doutim_d    = doutim_q;
        counter_d   = counter_q;
        out_last_d  = out_last_q;

        if (w_wr) begin
            wrow_d = wrow_q + 1'b1;
            if (wrow_q == ROW_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wrow_d          = '0;
            end
        end

        // A set and a clear never hit the same bank: writes stall on a full bank.
        if (w_load) begin
            doutre_d    = w_col_re;
            doutim_d    = w_col_im;
            counter_d   = rcol_q;
            out_last_d  = (rcol_q == ROW_LAST);
            out_valid_d = 1'b1;
            rcol_d      = rcol_q + 1'b1;
            if (rcol_q == ROW_LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcol_d          = '0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wrow_q      <= '0;
            rcol_q      <= '0;
            out_valid_q <= 1'b0;
            doutre_q    <= '0;
            doutim_q    <= '0;
            counter_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wrow_q      <= wrow_d;
            rcol_q      <= rcol_d;
            out_valid_q <= out_valid_d;
            doutre_q    <= doutre_d;
            doutim_q    <= doutim_d;
            counter_q   <= counter_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.doutre    = doutre_q;
    assign bus.doutim    = doutim_q;
    assign bus.counter   = {{(CW-PW){1'b0}}, counter_q};
    assign bus.out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft64_corner_turn.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft64_corner_turn
// Purpose  : Directed and randomised checks of the corner-turn buffer against
//            a transpose scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fft64_corner_turn;
    localparam int LANES   = 8;
    localparam int DW      = 10;
    localparam int CW      = 6;
    localparam int BW      = LANES * DW;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
        logic [CW-1:0] cnt;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rdy_cmd = 1'b0;
    logic rnd_en  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_beats  = 0;
    int n_acc    = 0;

    beat_t         exp_q[$];
    logic [BW-1:0] rows_re [LANES];
    logic [BW-1:0] rows_im [LANES];
    int            wrow_m = 0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_re, prev_im;
    logic [CW-1:0] prev_cnt;
    logic          prev_last;

    fft64_corner_turn_if #(.LANES(LANES), .DW(DW), .CW(CW)) bus ();

    fft64_corner_turn #(.LANES(LANES), .DW(DW), .CW(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.out_ready <= rnd_en ? ($urandom_range(0, 99) < 70) : rdy_cmd;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_row();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[BW-1:0];
    endfunction

    // Scoreboard: accepted rows build a frame, transposed into expected beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wrow_m     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", BW'(bus.out_valid), BW'(1));
                chk("hold_re", bus.doutre, prev_re);
                chk("hold_im", bus.doutim, prev_im);
                chk("hold_cnt", BW'(bus.counter), BW'(prev_cnt));
                chk("hold_last", BW'(bus.out_last), BW'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", BW'(1), BW'(0));
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_re", bus.doutre, e.re);
                    chk("beat_im", bus.doutim, e.im);
                    chk("beat_cnt", BW'(bus.counter), BW'(e.cnt));
                    chk("beat_last", BW'(bus.out_last), BW'(e.last));
                end
                n_beats++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_re    = bus.doutre;
            prev_im    = bus.doutim;
            prev_cnt   = bus.counter;
            prev_last  = bus.out_last;
            if (bus.in_valid && bus.in_ready) begin
                rows_re[wrow_m] = bus.dinre;
                rows_im[wrow_m] = bus.dinim;
                if (wrow_m == LANES - 1) begin
                    for (int c = 0; c < LANES; c++) begin
                        beat_t b;
                        for (int r = 0; r < LANES; r++) begin
                            b.re[DW*r +: DW] = rows_re[r][DW*c +: DW];
                            b.im[DW*r +: DW] = rows_im[r][DW*c +: DW];
                        end
                        b.cnt  = CW'(c);
                        b.last = (c == LANES - 1);
                        exp_q.push_back(b);
                    end
                    wrow_m = 0;
                end else begin
                    wrow_m++;
                end
            end
        end
    end

    task automatic drive_beat(input logic [BW-1:0] re, input logic [BW-1:0] im);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.dinre    = re;
        bus.dinim    = im;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < TIMEOUT) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("in_ready_timeout", BW'(0), BW'(1));
        else n_acc++;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pattern_frame();
        logic [BW-1:0] re, im;
        for (int r = 0; r < LANES; r++) begin
            for (int c = 0; c < LANES; c++) begin
                re[DW*c +: DW] = DW'(8 * r + c);
                im[DW*c +: DW] = DW'(8 * r + c + 64);
            end
            drive_beat(re, im);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", BW'(exp_q.size()), BW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] exp_re, exp_im, neg_re, neg_im;
        int            n;
        bus.in_valid = 1'b0;
        bus.dinre    = '0;
        bus.dinim    = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_re", bus.doutre, '0);
        chk("rst_im", bus.doutim, '0);
        chk("rst_cnt", BW'(bus.counter), BW'(0));
        chk("rst_last", BW'(bus.out_last), BW'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", BW'(bus.in_ready), BW'(1));
        rdy_cmd = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame: timing and hand-computed transpose
        fork
            send_pattern_frame();
            begin
                for (int k = 0; k < 17; k++) begin
                    @(negedge clk);
                    if (k == 8) chk("latency_early", BW'(bus.out_valid), BW'(0));
                    if (k >= 9) begin
                        for (int r = 0; r < LANES; r++) begin
                            exp_re[DW*r +: DW] = DW'(8 * r + (k - 9));
                            exp_im[DW*r +: DW] = DW'(8 * r + (k - 9) + 64);
                        end
                        chk("sf_valid", BW'(bus.out_valid), BW'(1));
                        chk("sf_cnt", BW'(bus.counter), BW'(k - 9));
                        chk("sf_last", BW'(bus.out_last), BW'(k == 16));
                        chk("sf_re", bus.doutre, exp_re);
                        chk("sf_im", bus.doutim, exp_im);
                    end
                end
            end
        join
        drain();

        // Reset mid-frame discards everything buffered
        rdy_cmd = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) drive_beat(rand_row(), rand_row());
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", BW'(bus.out_valid), BW'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", BW'(bus.out_valid), BW'(0));
        chk("mid_rst_re", bus.doutre, '0);
        chk("mid_rst_cnt", BW'(bus.counter), BW'(0));
        chk("mid_rst_last", BW'(bus.out_last), BW'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_cmd = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", BW'(bus.in_ready), BW'(1));
        @(posedge clk);
        #1;
        send_pattern_frame();
        drain();

        // Back-to-back: 4 frames, no bubbles on either side
        fork
            for (int i = 0; i < 4 * LANES; i++) drive_beat(rand_row(), rand_row());
            begin
                for (int k = 0; k < 41; k++) begin
                    @(negedge clk);
                    if (k < 32) chk("b2b_in_ready", BW'(bus.in_ready), BW'(1));
                    if (k == 8) chk("b2b_latency", BW'(bus.out_valid), BW'(0));
                    if (k >= 9) chk("b2b_out_valid", BW'(bus.out_valid), BW'(1));
                end
            end
        join
        drain();

        // Backpressure: 3 frames with the sink stalled
        rdy_cmd = 1'b0;
        @(posedge clk);
        #1;
        n_acc = 0;
        fork
            for (int i = 0; i < 3 * LANES; i++) drive_beat(rand_row(), rand_row());
            begin
                repeat (24) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", BW'(n_acc), BW'(16));
                chk("bp_in_ready", BW'(bus.in_ready), BW'(0));
                chk("bp_valid", BW'(bus.out_valid), BW'(1));
                chk("bp_cnt", BW'(bus.counter), BW'(0));
                rdy_cmd = 1'b1;
            end
        join
        drain();

        // Negative values move bit-exact
        neg_re = {LANES{10'h200}};
        neg_im = {LANES{10'h3FF}};
        for (int i = 0; i < LANES; i++) drive_beat(neg_re, neg_im);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < TIMEOUT);
        chk("neg_re", bus.doutre, neg_re);
        chk("neg_im", bus.doutim, neg_im);
        drain();

        // Random valid/ready over 1000 frames
        rnd_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            for (int r = 0; r < LANES; r++) begin
                if ($urandom_range(0, 99) < 30) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat(rand_row(), rand_row());
            end
        end
        rnd_en = 1'b0;
        drain();

        chk("total_beats", BW'(n_beats), BW'(8 * 1010));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
